// File: rtl/rs_entry_alloc_pkg.sv
// rs_pkg: shared sizing and index encoding for the reservation-station allocator
package rs_pkg;
  localparam int RS_SIZE = 4;
  localparam int RS_IW = $clog2(RS_SIZE) + 1;
  typedef logic [RS_IW-1:0] rs_idx_t;
  localparam rs_idx_t RS_IDX_NONE = '1;
endpackage

// File: rtl/rs_entry_alloc_free_pair_select.sv
// free_pair_select: highest and next-highest set bit of the free vector, all-ones when absent
module free_pair_select #(
  parameter int SIZE = 4,
  localparam int IW = $clog2(SIZE) + 1
) (
  input  logic [SIZE-1:0] free,
  output logic [IW-1:0]   idx0,
  output logic [IW-1:0]   idx1
);
  always_comb begin
    idx0 = '1;
    idx1 = '1;
    for (int i = 0; i < SIZE; i++)
      if (free[i]) begin
        idx1 = idx0;
        idx0 = IW'(i);
      end
  end
endmodule

// File: rtl/rs_entry_alloc.sv
// rs_entry_alloc: RS entry busy tracking, two allocs and two frees per cycle; sticky err output when RS_ALLOC_ERRCHK_EN is defined
module rs_entry_alloc
  import rs_pkg::*;
#(
  parameter int SIZE = RS_SIZE,
  localparam int IW = $clog2(SIZE) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            alloc_req0,
  input  logic            alloc_req1,
  output logic            alloc_gnt0,
  output logic            alloc_gnt1,
  output logic [IW-1:0]   alloc_idx0,
  output logic [IW-1:0]   alloc_idx1,
  input  logic            free_vld0,
  input  logic [IW-2:0]   free_idx0,
  input  logic            free_vld1,
  input  logic [IW-2:0]   free_idx1,
  output logic [SIZE-1:0] busy,
  output logic [IW-1:0]   free_cnt,
  output logic            full,
  output logic            empty
`ifdef RS_ALLOC_ERRCHK_EN
  ,
  output logic            err
`endif
);
  logic [SIZE-1:0] busy_next, set, clr, hit0, hit1;
  logic [IW-1:0] cnt_next;
  free_pair_select #(.SIZE(SIZE)) u_sel (
    .free(~busy),
    .idx0(alloc_idx0),
    .idx1(alloc_idx1)
  );
  assign alloc_gnt0 = rst_n & alloc_req0 & (free_cnt >= IW'(1)) & ~flush;
  assign alloc_gnt1 = rst_n & alloc_req0 & alloc_req1 & (free_cnt >= IW'(2)) & ~flush;
  assign full = free_cnt == '0;
  assign empty = free_cnt == IW'(SIZE);
  // an out-of-range free index shifts the one-hot off the end and clears nothing
  assign hit0 = free_vld0 ? SIZE'(1) << free_idx0 : '0;
  assign hit1 = free_vld1 ? SIZE'(1) << free_idx1 : '0;
  always_comb begin
    set = (alloc_gnt0 ? SIZE'(1) << alloc_idx0 : '0) | (alloc_gnt1 ? SIZE'(1) << alloc_idx1 : '0);
    clr = hit0 | hit1;
    busy_next = flush ? '0 : (busy & ~clr) | set;
    cnt_next = '0;
    for (int i = 0; i < SIZE; i++) cnt_next = cnt_next + IW'(!busy_next[i]);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      busy <= '0;
      free_cnt <= IW'(SIZE);
    end else begin
      busy <= busy_next;
      free_cnt <= cnt_next;
    end
`ifdef RS_ALLOC_ERRCHK_EN
  logic err_hit;
  assign err_hit = (free_vld0 & ~|(busy & hit0)) | (free_vld1 & ~|(busy & hit1));
  always_ff @(posedge clk)
    if (!rst_n) err <= 1'b0;
    else if (err_hit) err <= 1'b1;
`endif
endmodule

// File: tb/tb_rs_entry_alloc.sv
// tb_rs_entry_alloc: directed plus random checks of rs_entry_alloc against an array-of-entries model
module tb_rs_entry_alloc;
  localparam int SIZE = 4;
  localparam int IW = $clog2(SIZE) + 1;
  logic clk = 1'b0, rst_n, flush, alloc_req0, alloc_req1, free_vld0, free_vld1;
  logic [IW-2:0] free_idx0, free_idx1;
  logic alloc_gnt0, alloc_gnt1, full, empty;
  logic [IW-1:0] alloc_idx0, alloc_idx1, free_cnt;
  logic [SIZE-1:0] busy;
`ifdef RS_ALLOC_ERRCHK_EN
  logic err;
`endif
  int n_chk = 0, n_fail = 0;
  bit bm[SIZE];
  bit em;
  always #5 clk = ~clk;
  rs_entry_alloc #(.SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc_req0(alloc_req0), .alloc_req1(alloc_req1),
    .alloc_gnt0(alloc_gnt0), .alloc_gnt1(alloc_gnt1),
    .alloc_idx0(alloc_idx0), .alloc_idx1(alloc_idx1),
    .free_vld0(free_vld0), .free_idx0(free_idx0),
    .free_vld1(free_vld1), .free_idx1(free_idx1),
    .busy(busy), .free_cnt(free_cnt), .full(full), .empty(empty)
`ifdef RS_ALLOC_ERRCHK_EN
    , .err(err)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input bit r, input bit fl, input bit q0, input bit q1,
                      input bit v0, input logic [IW-2:0] i0, input bit v1, input logic [IW-2:0] i1);
    int fc, e0, e1;
    bit g0, g1;
    logic [SIZE-1:0] eb;
    @(negedge clk);
    rst_n = r; flush = fl; alloc_req0 = q0; alloc_req1 = q1;
    free_vld0 = v0; free_idx0 = i0; free_vld1 = v1; free_idx1 = i1;
    #1;
    fc = 0; e0 = -1; e1 = -1;
    for (int i = SIZE - 1; i >= 0; i--) begin
      eb[i] = bm[i];
      if (!bm[i]) begin
        fc++;
        if (e0 < 0) e0 = i;
        else if (e1 < 0) e1 = i;
      end
    end
    g0 = r && q0 && fc >= 1 && !fl;
    g1 = r && q0 && q1 && fc >= 2 && !fl;
    chk("gnt0", alloc_gnt0, g0);
    chk("gnt1", alloc_gnt1, g1);
    chk("idx0", alloc_idx0, e0 < 0 ? {IW{1'b1}} : IW'(e0));
    chk("idx1", alloc_idx1, e1 < 0 ? {IW{1'b1}} : IW'(e1));
    chk("busy", busy, eb);
    chk("free_cnt", free_cnt, fc);
    chk("full", full, fc == 0);
    chk("empty", empty, fc == SIZE);
`ifdef RS_ALLOC_ERRCHK_EN
    chk("err", err, em);
`endif
    @(posedge clk);
    if (!r) begin
      foreach (bm[i]) bm[i] = 0;
      em = 0;
    end else begin
      if (v0 && (int'(i0) >= SIZE || !bm[i0])) em = 1;
      if (v1 && (int'(i1) >= SIZE || !bm[i1])) em = 1;
      if (fl) foreach (bm[i]) bm[i] = 0;
      else begin
        if (v0 && int'(i0) < SIZE) bm[i0] = 0;
        if (v1 && int'(i1) < SIZE) bm[i1] = 0;
        if (g0) bm[e0] = 1;
        if (g1) bm[e1] = 1;
      end
    end
  endtask
  initial begin
    rst_n = 0; flush = 0; alloc_req0 = 0; alloc_req1 = 0;
    free_vld0 = 0; free_idx0 = 0; free_vld1 = 0; free_idx1 = 0;
    foreach (bm[i]) bm[i] = 0;
    em = 0;
    repeat (2) @(posedge clk);
    step(1, 0, 1, 1, 0, 0, 0, 0);
    #2 chk("tp_busy_1100", busy, 4'b1100);
    chk("tp_cnt_2", free_cnt, 2);
    step(1, 0, 1, 1, 0, 0, 0, 0);
    #2 chk("tp_busy_1111", busy, 4'b1111);
    chk("tp_full", full, 1);
    chk("tp_idx0_none", alloc_idx0, 3'b111);
    step(1, 0, 1, 0, 1, 2, 0, 0);
    #2 chk("tp_busy_1011", busy, 4'b1011);
    chk("tp_idx0_2", alloc_idx0, 2);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0, 1, 3);
    #2 chk("tp_busy_0110", busy, 4'b0110);
    step(1, 0, 0, 0, 1, 1, 1, 1);
    #2 chk("tp_busy_0100", busy, 4'b0100);
    chk("tp_cnt_3", free_cnt, 3);
    step(1, 0, 0, 0, 1, 0, 0, 0);
    #2 chk("tp_free_idle", busy, 4'b0100);
    step(1, 0, 1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 1, 2, 0, 0);
    #2 chk("tp_flush_busy", busy, 4'b0000);
    chk("tp_flush_cnt", free_cnt, 4);
    chk("tp_flush_empty", empty, 1);
    step(1, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0, 0);
    #2 chk("tp_req1_only", busy, 4'b1000);
    step(0, 0, 1, 1, 1, 3, 0, 0);
    #2 chk("tp_rst_busy", busy, 4'b0000);
    chk("tp_rst_cnt", free_cnt, 4);
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 49) != 0, $urandom_range(0, 19) == 0,
           1'($urandom), 1'($urandom), 1'($urandom), (IW-1)'($urandom),
           1'($urandom), (IW-1)'($urandom));
    step(1, 0, 0, 0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
